// File: rtl/jtag_shift_engine_if.sv
// Host command/response handshake plus virtual JTAG bus for jtag_shift_engine.
// The engine connects through the slave modport; the host/chain side uses master.
interface jtag_shift_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_tms;
  logic [31:0] cmd_tdi;
  logic [3:0]  cmd_sel;
  logic        abort;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_tdo;
  logic        busy;
  logic [3:0]  jtag_sel;
  logic        v_tck;
  logic        v_tms;
  logic        v_tdi;
  logic        v_tdo;

  modport master (
    output cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_sel, abort, rsp_ready, v_tdo,
    input  cmd_ready, rsp_valid, rsp_tdo, busy, jtag_sel, v_tck, v_tms, v_tdi
  );

  modport slave (
    input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, cmd_sel, abort, rsp_ready, v_tdo,
    output cmd_ready, rsp_valid, rsp_tdo, busy, jtag_sel, v_tck, v_tms, v_tdi
  );
endinterface

// File: rtl/jtag_shift_engine.sv
// Command-driven JTAG shift engine: shifts up to 32 TMS/TDI bits LSB first and returns captured TDO.
// Define JTAG_SHIFT_TLR_ON_RESET_EN to walk the chains to Test-Logic-Reset (5 TMS=1 clocks) after reset.
module jtag_shift_engine #(
  parameter int TCK_HALF = 4,
  parameter int MAX_BITS = 32
) (
  input logic                clk,
  input logic                rst_n,
  jtag_shift_engine_if.slave bus
);

`ifdef JTAG_SHIFT_TLR_ON_RESET_EN
  localparam bit TLR_EN = 1'b1;
`else
  localparam bit TLR_EN = 1'b0;
`endif

  localparam logic [7:0] HALF_LAST = 8'(TCK_HALF - 1);
  localparam logic [5:0] TLR_LEN   = 6'd5;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t              state_q, state_nx;
  logic [7:0]          cnt_q, cnt_nx;
  logic [4:0]          idx_q, idx_nx;
  logic [5:0]          len_q;
  logic [MAX_BITS-1:0] tms_q, tdi_q, cap_q;
  logic                tlr_q, tlr_pend_q, tlr_pend_nx;
  logic                accept, tlr_start, half_done, last_bit, abort_hit, rsp_valid_nx;

  function automatic logic [5:0] sat_len(input logic [5:0] len);
    return (len > 6'(MAX_BITS)) ? 6'(MAX_BITS) : len;
  endfunction

  always_comb begin
    accept    = bus.cmd_valid && bus.cmd_ready;
    tlr_start = (state_q == IDLE) && tlr_pend_q;
    half_done = (cnt_q == HALF_LAST);
    last_bit  = ({1'b0, idx_q} == (len_q - 6'd1));
    // the reset walk must complete, so it cannot be aborted
    abort_hit = bus.abort && !tlr_q;
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    idx_nx    = idx_q;
    case (state_q)
      IDLE: begin
        if (tlr_start || accept) begin
          state_nx = (accept && sat_len(bus.cmd_len) == 6'd0) ? DONE : LOW;
          cnt_nx   = 8'd0;
          idx_nx   = 5'd0;
        end
      end
      LOW: begin
        if (abort_hit) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else if (half_done) begin
          state_nx = HIGH;
          cnt_nx   = 8'd0;
        end else begin
          cnt_nx = cnt_q + 8'd1;
        end
      end
      HIGH: begin
        if (abort_hit) begin
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end else if (half_done) begin
          cnt_nx = 8'd0;
          if (last_bit) begin
            state_nx = tlr_q ? IDLE : DONE;
          end else begin
            state_nx = LOW;
            idx_nx   = idx_q + 5'd1;
          end
        end else begin
          cnt_nx = cnt_q + 8'd1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    rsp_valid_nx = (state_nx == DONE) || (bus.rsp_valid && !bus.rsp_ready);
    tlr_pend_nx  = tlr_pend_q && !tlr_start;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      idx_q         <= 5'd0;
      tlr_q         <= 1'b0;
      tlr_pend_q    <= TLR_EN;
      bus.cmd_ready <= !TLR_EN;
      bus.rsp_valid <= 1'b0;
      bus.rsp_tdo   <= '0;
      bus.busy      <= 1'b0;
      bus.jtag_sel  <= 4'hF;
      bus.v_tck     <= 1'b0;
      bus.v_tms     <= 1'b1;
      bus.v_tdi     <= 1'b0;
    end else begin
      state_q       <= state_nx;
      cnt_q         <= cnt_nx;
      idx_q         <= idx_nx;
      tlr_pend_q    <= tlr_pend_nx;
      bus.cmd_ready <= (state_nx == IDLE) && !rsp_valid_nx && !tlr_pend_nx;
      bus.rsp_valid <= rsp_valid_nx;
      bus.v_tck     <= (state_nx == HIGH);
      if (tlr_start) begin
        tlr_q        <= 1'b1;
        bus.busy     <= 1'b1;
        bus.jtag_sel <= 4'hF;
        bus.v_tms    <= 1'b1;
        bus.v_tdi    <= 1'b0;
      end else if (accept) begin
        bus.busy     <= 1'b1;
        bus.jtag_sel <= bus.cmd_sel;
        // latched vectors are not valid yet, so bit 0 comes straight from the command
        if (state_nx == LOW) begin
          bus.v_tms <= bus.cmd_tms[0];
          bus.v_tdi <= bus.cmd_tdi[0];
        end
      end else if (state_q == HIGH && state_nx == LOW) begin
        bus.v_tms <= tms_q[idx_nx];
        bus.v_tdi <= tdi_q[idx_nx];
      end
      if ((state_q == LOW || state_q == HIGH) && state_nx == IDLE) begin
        tlr_q    <= 1'b0;
        bus.busy <= 1'b0;
      end
      if (state_nx == DONE) begin
        bus.busy    <= 1'b0;
        bus.rsp_tdo <= (state_q == IDLE) ? '0 : cap_q;
      end else if (bus.rsp_valid && bus.rsp_ready) begin
        bus.rsp_tdo <= '0;
      end
    end
  end

  // Scan vectors and capture register carry data only and need no reset.
  always_ff @(posedge clk) begin
    if (tlr_start) begin
      len_q <= TLR_LEN;
      tms_q <= '1;
      tdi_q <= '0;
    end else if (accept) begin
      len_q <= sat_len(bus.cmd_len);
      tms_q <= bus.cmd_tms;
      tdi_q <= bus.cmd_tdi;
      cap_q <= '0;
    end else if (state_q == LOW && state_nx == HIGH) begin
      cap_q[idx_q] <= bus.v_tdo;
    end
  end

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Randomized bench for jtag_shift_engine: each command is checked against a
// transaction-level model (bit streams, TDO word, latency, pulse counts).
module tb_jtag_shift_engine;
  localparam int TH = 2;

  logic clk = 1'b0;
  logic rst_n;

  jtag_shift_engine_if bus();

  jtag_shift_engine #(.TCK_HALF(TH), .MAX_BITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          fall_base = 0;
  int          tdo_mode = 0;
  logic [31:0] tdo_vec = '0;
  logic [4:0]  tdo_idx;
  logic        tms_seen [0:8191];
  logic        tdi_seen [0:8191];

  // Chain model: record TMS/TDI at each rising TCK, present TDO bit per falling TCK.
  always @(posedge bus.v_tck) begin
    tms_seen[rise_cnt % 8192] = bus.v_tms;
    tdi_seen[rise_cnt % 8192] = bus.v_tdi;
    rise_cnt++;
  end

  always @(negedge bus.v_tck) fall_cnt++;

  always_comb begin
    tdo_idx = 5'(fall_cnt - fall_base);
    case (tdo_mode)
      0:       bus.v_tdo = bus.v_tdi;
      1:       bus.v_tdo = 1'b1;
      default: bus.v_tdo = tdo_vec[tdo_idx];
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int len);
    return (len > 32) ? 32 : len;
  endfunction

  function automatic logic [31:0] mask_of(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  task automatic drive_idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_tms   = '0;
    bus.cmd_tdi   = '0;
    bus.cmd_sel   = '0;
    bus.abort     = 1'b0;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, ".v_tck"},     32'(bus.v_tck),     32'd0);
    chk({pfx, ".v_tms"},     32'(bus.v_tms),     32'd1);
    chk({pfx, ".v_tdi"},     32'(bus.v_tdi),     32'd0);
    chk({pfx, ".jtag_sel"},  32'(bus.jtag_sel),  32'hF);
    chk({pfx, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({pfx, ".rsp_tdo"},   bus.rsp_tdo,        32'd0);
    chk({pfx, ".busy"},      32'(bus.busy),      32'd0);
  endtask

  // Called at the negedge where rst_n has just been released.
  task automatic after_reset(input string pfx);
`ifdef JTAG_SHIFT_TLR_ON_RESET_EN
    int base;
    int cyc;
    bit tms_ok;
    base   = rise_cnt;
    cyc    = 0;
    tms_ok = 1'b1;
    while (!bus.cmd_ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk({pfx, ".tlr_pulses"}, 32'(rise_cnt - base), 32'd5);
    for (int i = 0; i < 5; i++) tms_ok &= (tms_seen[(base + i) % 8192] === 1'b1);
    chk({pfx, ".tlr_tms"}, 32'(tms_ok), 32'd1);
`else
    @(negedge clk);
    chk({pfx, ".ready"}, 32'(bus.cmd_ready), 32'd1);
`endif
  endtask

  // Issue one command, check the response against the model, then release it.
  task automatic run_cmd(input logic [5:0] len, input logic [31:0] tms, input logic [31:0] tdi,
                         input logic [3:0] sel, input int mode, input logic [31:0] tdo_r,
                         input int hold, input bit abort_too, input string tag);
    int          n, exp_lat, cyc, hi_cyc, base, wcyc;
    bit          sel_ok, busy_ok, stream_ok, hold_ok;
    logic [31:0] exp_tdo, held_tdo;
    n       = sat(int'(len));
    exp_lat = (n == 0) ? 1 : 2 * TH * n + 1;
    case (mode)
      0:       exp_tdo = tdi & mask_of(n);
      1:       exp_tdo = mask_of(n);
      default: exp_tdo = tdo_r & mask_of(n);
    endcase
    tdo_mode      = mode;
    tdo_vec       = tdo_r;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = len;
    bus.cmd_tms   = tms;
    bus.cmd_tdi   = tdi;
    bus.cmd_sel   = sel;
    bus.abort     = abort_too;
    wcyc = 0;
    while (!bus.cmd_ready && wcyc < 300) begin
      @(negedge clk);
      wcyc++;
    end
    if (!bus.cmd_ready) begin
      chk({tag, ".accept_timeout"}, 32'(bus.cmd_ready), 32'd1);
      drive_idle();
      return;
    end
    base      = rise_cnt;
    fall_base = fall_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.abort     = 1'b0;
    cyc     = 1;
    hi_cyc  = 0;
    sel_ok  = 1'b1;
    busy_ok = 1'b1;
    while (!bus.rsp_valid && cyc < exp_lat + 50) begin
      sel_ok  &= (bus.jtag_sel === sel);
      busy_ok &= (bus.busy === 1'b1);
      hi_cyc  += int'(bus.v_tck);
      @(negedge clk);
      cyc++;
    end
    sel_ok  &= (bus.jtag_sel === sel);
    busy_ok &= (bus.busy === 1'b0) && (bus.v_tck === 1'b0);
    chk({tag, ".latency"},   32'(cyc),               32'(exp_lat));
    chk({tag, ".rsp_tdo"},   bus.rsp_tdo,            exp_tdo);
    chk({tag, ".pulses"},    32'(rise_cnt - base),   32'(n));
    chk({tag, ".hi_cycles"}, 32'(hi_cyc),            32'(n * TH));
    stream_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      stream_ok &= (tms_seen[(base + i) % 8192] === tms[i]);
      stream_ok &= (tdi_seen[(base + i) % 8192] === tdi[i]);
    end
    chk({tag, ".stream"}, 32'(stream_ok), 32'd1);
    chk({tag, ".sel"},    32'(sel_ok),    32'd1);
    chk({tag, ".busy"},   32'(busy_ok),   32'd1);
    held_tdo = bus.rsp_tdo;
    hold_ok  = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      hold_ok &= (bus.rsp_valid === 1'b1) && (bus.rsp_tdo === held_tdo) &&
                 (bus.cmd_ready === 1'b0) && (bus.jtag_sel === sel) && (bus.v_tck === 1'b0);
    end
    chk({tag, ".hold"}, 32'(hold_ok), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, ".release"}, {29'd0, bus.rsp_valid, bus.cmd_ready, |bus.rsp_tdo}, 32'b010);
  endtask

  task automatic abort_test();
    int base, cyc;
    bit quiet;
    tdo_mode      = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 6'd10;
    bus.cmd_tms   = $urandom;
    bus.cmd_tdi   = $urandom;
    bus.cmd_sel   = 4'd5;
    base = rise_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc = 0;
    while ((rise_cnt - base) < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort.pre_pulses", 32'(rise_cnt - base), 32'd3);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort.v_tck",     32'(bus.v_tck),     32'd0);
    chk("abort.busy",      32'(bus.busy),      32'd0);
    chk("abort.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    quiet = 1'b1;
    for (int k = 0; k < 30; k++) begin
      quiet &= (bus.rsp_valid === 1'b0) && (bus.jtag_sel === 4'd5);
      @(negedge clk);
    end
    chk("abort.no_rsp",     32'(quiet),           32'd1);
    chk("abort.no_pulses",  32'(rise_cnt - base), 32'd3);
  endtask

  task automatic reset_test();
    int base, cyc;
    tdo_mode      = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = 6'd20;
    bus.cmd_tms   = $urandom;
    bus.cmd_tdi   = $urandom;
    bus.cmd_sel   = 4'd6;
    base = rise_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc = 0;
    while ((rise_cnt - base) < 4 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid.pre_pulses", 32'(rise_cnt - base), 32'd4);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    after_reset("rst_mid");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    after_reset("post_reset");

    run_cmd(6'd8,  32'h0000_0000, 32'h0000_00A5, 4'd3,  0, 32'h0, 0, 1'b0, "loop_a5");
    run_cmd(6'd32, $urandom,      32'hDEAD_BEEF, 4'd7,  1, 32'h0, 0, 1'b0, "len32_tdo1");
    run_cmd(6'd0,  $urandom,      $urandom,      4'd11, 2, $urandom, 0, 1'b0, "len0");
    run_cmd(6'd40, $urandom,      $urandom,      4'd2,  2, $urandom, 0, 1'b0, "len40");
    run_cmd(6'd5,  $urandom,      $urandom,      4'd9,  2, $urandom, 20, 1'b0, "hold20");
    abort_test();
    run_cmd(6'd12, $urandom,      $urandom,      4'd13, 2, $urandom, 1, 1'b0, "post_abort");
    run_cmd(6'd3,  $urandom,      $urandom,      4'd0,  0, 32'h0, 0, 1'b1, "abort_with_cmd");

    for (int r = 0; r < 16; r++) begin
      run_cmd(6'($urandom_range(0, 63)), $urandom, $urandom, 4'($urandom_range(0, 15)),
              int'($urandom_range(0, 2)), $urandom, int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), "rand");
    end

    reset_test();
    run_cmd(6'd7, $urandom, $urandom, 4'd4, 2, $urandom, 2, 1'b0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
